// File: rtl/ide_devctl.sv
// ATA Device Control / Alternate Status responder for port 0x3F6.
// Optional HOB tracking enabled by defining IDE_DEVCTL_HOB_EN.
module ide_devctl #(
    parameter int unsigned RECOVER_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ide_3f6_read,
    output logic [7:0] ide_3f6_readdata,
    input  logic       ide_3f6_write,
    input  logic [7:0] ide_3f6_writedata,
    input  logic [7:0] core_status,
    input  logic       core_irq,
    input  logic       core_taskfile_write,
    output logic       core_srst,
    output logic       core_sig_load,
    output logic       irq,
    output logic       nien,
    output logic       hob
);

    localparam int CW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(RECOVER_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sig_load_q, sig_load_d;
    logic          nien_q;
    logic          hob_q;
    logic          irq_q;
    logic [7:0]    status_q;

    logic wr_srst;
    logic wr_clr;

    assign wr_srst = ide_3f6_write & ide_3f6_writedata[2];
    assign wr_clr  = ide_3f6_write & ~ide_3f6_writedata[2];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sig_load_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sig_load_q <= sig_load_d;
        end
    end

    // Next-state logic; a new SRST during recovery abandons the countdown
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sig_load_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wr_srst) state_d = ASSERT;
            end
            ASSERT: begin
                if (wr_clr) begin
                    state_d = RECOVER;
                    cnt_d   = CNT_LOAD;
                end
            end
            RECOVER: begin
                if (wr_srst) begin
                    state_d = ASSERT;
                end else if (cnt_q == '0) begin
                    state_d    = IDLE;
                    sig_load_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        core_srst        = (state_q != IDLE);
        ide_3f6_readdata = core_srst ? 8'h80 : status_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nien_q   <= 1'b0;
            irq_q    <= 1'b0;
            status_q <= 8'h00;
        end else begin
            status_q <= core_status;
            irq_q    <= core_irq & ~nien_q & (state_q == IDLE);
            if (ide_3f6_write) nien_q <= ide_3f6_writedata[1];
        end
    end

`ifdef IDE_DEVCTL_HOB_EN
    // Device Control write takes priority over a task-file clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hob_q <= 1'b0;
        end else if (ide_3f6_write) begin
            hob_q <= ide_3f6_writedata[7];
        end else if (core_taskfile_write) begin
            hob_q <= 1'b0;
        end
    end

    logic unused_in;
    assign unused_in = ^{ide_3f6_read, ide_3f6_writedata[6:3],
                         ide_3f6_writedata[0]};
`else
    assign hob_q = 1'b0;

    logic unused_in;
    assign unused_in = ^{ide_3f6_read, ide_3f6_writedata[7:3],
                         ide_3f6_writedata[0], core_taskfile_write};
`endif

    assign core_sig_load = sig_load_q;
    assign irq           = irq_q;
    assign nien          = nien_q;
    assign hob           = hob_q;

endmodule

// File: tb/tb_ide_devctl.sv
// Directed scoreboard bench for ide_devctl.
// Expected values are queued at stimulus time and compared after the edge.
module tb_ide_devctl;

    localparam int unsigned RC = 16;

    logic       clk;
    logic       rst_n;
    logic       ide_3f6_read;
    logic [7:0] ide_3f6_readdata;
    logic       ide_3f6_write;
    logic [7:0] ide_3f6_writedata;
    logic [7:0] core_status;
    logic       core_irq;
    logic       core_taskfile_write;
    logic       core_srst;
    logic       core_sig_load;
    logic       irq;
    logic       nien;
    logic       hob;

    ide_devctl #(.RECOVER_CYCLES(RC)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ide_3f6_read        (ide_3f6_read),
        .ide_3f6_readdata    (ide_3f6_readdata),
        .ide_3f6_write       (ide_3f6_write),
        .ide_3f6_writedata   (ide_3f6_writedata),
        .core_status         (core_status),
        .core_irq            (core_irq),
        .core_taskfile_write (core_taskfile_write),
        .core_srst           (core_srst),
        .core_sig_load       (core_sig_load),
        .irq                 (irq),
        .nien                (nien),
        .hob                 (hob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    task automatic push(input string tag, input logic [7:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [7:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty: observed %h expected <queued>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp)
            else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_srst(input string tag, input logic s, input logic l);
        push({tag, "_srst"}, {7'd0, s});
        push({tag, "_sigld"}, {7'd0, l});
        pop_chk({7'd0, core_srst});
        pop_chk({7'd0, core_sig_load});
    endtask

    task automatic chk_reset(input string tag);
        push({tag, "_rd"}, 8'h00);
        push({tag, "_irq"}, 8'h00);
        push({tag, "_nien"}, 8'h00);
        push({tag, "_hob"}, 8'h00);
        pop_chk(ide_3f6_readdata);
        pop_chk({7'd0, irq});
        pop_chk({7'd0, nien});
        pop_chk({7'd0, hob});
        chk_srst(tag, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [7:0] d);
        ide_3f6_write     = 1'b1;
        ide_3f6_writedata = d;
        step();
        ide_3f6_write     = 1'b0;
        ide_3f6_writedata = 8'h00;
    endtask

    initial begin
        vectors             = 0;
        miscompares         = 0;
        rst_n               = 1'b0;
        ide_3f6_read        = 1'b0;
        ide_3f6_write       = 1'b0;
        ide_3f6_writedata   = 8'h00;
        core_status         = 8'h00;
        core_irq            = 1'b0;
        core_taskfile_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        step();

        // Status sampling and irq passthrough
        core_status = 8'h50;
        core_irq    = 1'b1;
        push("status_1", 8'h50);
        push("irq_on", 8'h01);
        step();
        pop_chk(ide_3f6_readdata);
        pop_chk({7'd0, irq});

        // Reads never disturb irq
        ide_3f6_read = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push("read_irq", 8'h01);
            push("read_rd", 8'h50);
            step();
            pop_chk({7'd0, irq});
            pop_chk(ide_3f6_readdata);
        end
        ide_3f6_read = 1'b0;

        // nIEN gating with one-cycle irq latency
        push("nien_set", 8'h01);
        push("irq_lag", 8'h01);
        wr(8'h02);
        pop_chk({7'd0, nien});
        pop_chk({7'd0, irq});
        push("irq_masked", 8'h00);
        step();
        pop_chk({7'd0, irq});
        push("nien_clr", 8'h00);
        push("irq_still_off", 8'h00);
        wr(8'h00);
        pop_chk({7'd0, nien});
        pop_chk({7'd0, irq});
        push("irq_back", 8'h01);
        step();
        pop_chk({7'd0, irq});
        core_irq = 1'b0;
        step();

        // SRST sequence; simultaneous read sees pre-write value
        ide_3f6_read = 1'b1;
        ide_3f6_write = 1'b1;
        ide_3f6_writedata = 8'h04;
        #1;
        push("rd_prewrite", 8'h50);
        pop_chk(ide_3f6_readdata);
        step();
        ide_3f6_read = 1'b0;
        ide_3f6_write = 1'b0;
        ide_3f6_writedata = 8'h00;
        chk_srst("assert", 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            push("assert_rd", 8'h80);
            step();
            pop_chk(ide_3f6_readdata);
            chk_srst("assert_hold", 1'b1, 1'b0);
        end
        wr(8'h00);
        chk_srst("recover_1", 1'b1, 1'b0);
        for (int i = 2; i <= int'(RC); i++) begin
            push("recover_rd", 8'h80);
            step();
            pop_chk(ide_3f6_readdata);
            chk_srst("recover_n", 1'b1, 1'b0);
        end
        push("done_rd", 8'h50);
        step();
        pop_chk(ide_3f6_readdata);
        chk_srst("done", 1'b0, 1'b1);
        step();
        chk_srst("after_done", 1'b0, 1'b0);

        // Re-assert during recovery abandons the countdown
        wr(8'h04);
        wr(8'h00);
        step();
        step();
        wr(8'h04);
        for (int i = 0; i < int'(RC) + 4; i++) begin
            step();
            chk_srst("reassert", 1'b1, 1'b0);
        end

        // Reset at counter == 7 during recovery
        wr(8'h00);
        repeat (8) step();
        chk_srst("pre_rst", 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        step();
        rst_n = 1'b1;
        for (int i = 0; i < int'(RC) + 4; i++) begin
            step();
            chk_srst("post_rst", 1'b0, 1'b0);
        end

        // HOB handling
`ifdef IDE_DEVCTL_HOB_EN
        push("hob_set", 8'h01);
        wr(8'h80);
        pop_chk({7'd0, hob});
        push("hob_tf_clr", 8'h00);
        core_taskfile_write = 1'b1;
        step();
        core_taskfile_write = 1'b0;
        pop_chk({7'd0, hob});
        push("hob_wr_wins", 8'h01);
        core_taskfile_write = 1'b1;
        wr(8'h80);
        core_taskfile_write = 1'b0;
        pop_chk({7'd0, hob});
`else
        push("hob_off", 8'h00);
        wr(8'h80);
        pop_chk({7'd0, hob});
        push("hob_off_tf", 8'h00);
        core_taskfile_write = 1'b1;
        step();
        core_taskfile_write = 1'b0;
        pop_chk({7'd0, hob});
`endif
        push("hob_nien", 8'h00);
        pop_chk({7'd0, nien});

        if (sb.size() != 0) begin
            miscompares++;
            $error("FAIL sb_leftover: observed %0d expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
